// File: rtl/fn_bank_sweep_ctrl.sv
// Sweep sequencer for a 2-input Boolean function bank: drives 4 vectors, captures truth tables, compares.
// Optional `SWEEP_LOOP_EN adds back-to-back looping (loop) and a sticky failure flag (sticky_fail).
module fn_bank_sweep_ctrl #(
  parameter int NUM_OUT       = 19,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
`ifdef SWEEP_LOOP_EN
  input  logic                 loop,
  output logic                 sticky_fail,
`endif
  output logic                 x0,
  output logic                 x1,
  input  logic [NUM_OUT-1:0]   f_in,
  input  logic [4*NUM_OUT-1:0] exp_tt,
  output logic [4*NUM_OUT-1:0] tt_out,
  output logic [NUM_OUT-1:0]   mismatch,
  output logic                 pass,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  state_t state;
  state_t state_nxt;

  logic [1:0] idx;
  logic [3:0] cnt;

  logic go;
  logic launch;
  logic cap;
  logic step;
  logic fin;

  logic [4*NUM_OUT-1:0] tt_nxt;
  logic [NUM_OUT-1:0]   mis_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort beats a capture on the same edge
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    launch    = 1'b0;
    cap       = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = SETTLE;
          go        = 1'b1;
          launch    = 1'b1;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          cap = 1'b1;
          if (idx == 2'd3) begin
            fin       = 1'b1;
            state_nxt = DONE;
          end else begin
            step      = 1'b1;
            state_nxt = SETTLE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
`ifdef SWEEP_LOOP_EN
        if (loop && !abort) begin
          state_nxt = SETTLE;
          go        = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tt_nxt = tt_out;
    if (cap) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        tt_nxt[4*k + int'(idx)] = f_in[k];
      end
    end
  end

  // compare uses the table including the bit captured on this edge
  always_comb begin
    mis_nxt = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      mis_nxt[k] = tt_nxt[4*k +: 4] != exp_tt[4*k +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      cnt          <= '0;
      tt_out       <= '0;
      mismatch     <= '0;
      pass         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      if (go) begin
        idx          <= '0;
        cnt          <= '0;
        result_valid <= 1'b0;
      end else if (step) begin
        idx <= idx + 2'd1;
        cnt <= '0;
      end else if (state == SETTLE && !abort) begin
        cnt <= cnt + 4'd1;
      end
      if (cap) begin
        tt_out <= tt_nxt;
      end
      if (fin) begin
        mismatch     <= mis_nxt;
        pass         <= ~|mis_nxt;
        result_valid <= 1'b1;
      end
    end
  end

`ifdef SWEEP_LOOP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_fail <= 1'b0;
    end else if (launch) begin
      sticky_fail <= 1'b0;
    end else if (fin) begin
      sticky_fail <= sticky_fail | (|mis_nxt);
    end
  end
`else
  logic unused_launch;
  assign unused_launch = launch;
`endif

  assign x0   = idx[0];
  assign x1   = idx[1];
  assign busy = (state == SETTLE) || (state == CAPTURE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_fn_bank_sweep_ctrl.sv
// Bench for fn_bank_sweep_ctrl: directed literal checks plus random
// start/abort traffic against a time-since-start behavioural model.
module tb_fn_bank_sweep_ctrl;
  localparam int N  = 2;
  localparam int S  = 1;
  localparam int S3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [4*N-1:0] bank_tt;
  logic [4*N-1:0] exp_tt;

  logic x0, x1, pass, rv, busy, done;
  logic [N-1:0] f_in, mismatch;
  logic [4*N-1:0] tt_out;

  logic x0b, x1b, passb, rvb, busyb, doneb;
  logic [N-1:0] f_inb, mismatchb;
  logic [4*N-1:0] tt_outb;

`ifdef SWEEP_LOOP_EN
  logic loop = 1'b0;
  logic sticky, stickyb;
`endif

  always #5 clk = ~clk;

  always_comb begin
    f_in  = '0;
    f_inb = '0;
    for (int k = 0; k < N; k++) begin
      f_in[k]  = bank_tt[4*k + int'({x1, x0})];
      f_inb[k] = bank_tt[4*k + int'({x1b, x0b})];
    end
  end

  fn_bank_sweep_ctrl #(.NUM_OUT(N), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef SWEEP_LOOP_EN
    .loop(loop), .sticky_fail(sticky),
`endif
    .x0(x0), .x1(x1), .f_in(f_in), .exp_tt(exp_tt),
    .tt_out(tt_out), .mismatch(mismatch), .pass(pass),
    .result_valid(rv), .busy(busy), .done(done)
  );

  fn_bank_sweep_ctrl #(.NUM_OUT(N), .SETTLE_CYCLES(S3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef SWEEP_LOOP_EN
    .loop(loop), .sticky_fail(stickyb),
`endif
    .x0(x0b), .x1(x1b), .f_in(f_inb), .exp_tt(exp_tt),
    .tt_out(tt_outb), .mismatch(mismatchb), .pass(passb),
    .result_valid(rvb), .busy(busyb), .done(doneb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, longint unsigned act, longint unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // model: 0 idle, 1 sweeping (t = cycles since start), 2 done
  int m_phase;
  int m_t;
  logic [1:0] m_x;
  logic [4*N-1:0] m_tt;
  logic [N-1:0] m_mis;
  logic m_pass, m_rv, m_sticky;

  always @(posedge clk or negedge rst_n) begin : model
    int ph, t, v;
    logic [1:0] xv;
    logic [4*N-1:0] tt;
    logic [N-1:0] mis;
    logic ps, r, st;
    if (!rst_n) begin
      m_phase  <= 0;
      m_t      <= 0;
      m_x      <= '0;
      m_tt     <= '0;
      m_mis    <= '0;
      m_pass   <= 1'b0;
      m_rv     <= 1'b0;
      m_sticky <= 1'b0;
    end else begin
      ph = m_phase; t = m_t; xv = m_x; tt = m_tt;
      mis = m_mis; ps = m_pass; r = m_rv; st = m_sticky;
      case (ph)
        0: if (start && !abort) begin
          ph = 1; t = 0; xv = 2'd0; r = 1'b0; st = 1'b0;
        end
        1: if (abort) begin
          ph = 0;
        end else begin
          v = t / (S + 1);
          if (t % (S + 1) == S) begin
            for (int k = 0; k < N; k++) tt[4*k + v] = bank_tt[4*k + v];
            if (v == 3) begin
              for (int k = 0; k < N; k++)
                mis[k] = tt[4*k +: 4] != exp_tt[4*k +: 4];
              ps = (mis == '0);
              r  = 1'b1;
              st = st | !ps;
              ph = 2;
            end
          end
          if (ph == 1) begin
            t++;
            xv = 2'(t / (S + 1));
          end
        end
        default: ph = 0;
      endcase
      m_phase <= ph; m_t <= t; m_x <= xv; m_tt <= tt;
      m_mis <= mis; m_pass <= ps; m_rv <= r; m_sticky <= st;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("x", {x1, x0}, m_x);
      chk("busy", busy, m_phase == 1);
      chk("done", done, m_phase == 2);
      chk("tt_out", tt_out, m_tt);
      chk("mismatch", mismatch, m_mis);
      chk("pass", pass, m_pass);
      chk("result_valid", rv, m_rv);
`ifdef SWEEP_LOOP_EN
      chk("sticky_fail", sticky, m_sticky);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bank_tt = 8'b0001_1000;
    exp_tt  = 8'b0001_1000;
    #11;
    chk("reset_outputs", {x1, x0, busy, done, pass, rv, tt_out, mismatch}, 0);
    #1 rst_n = 1'b1;
    tick();

    // pass sweep, latency, and SETTLE_CYCLES=3 vector trace
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      if (j < 16) begin
        chk("trace3_x", {x1b, x0b}, j / 4);
        chk("trace3_busy", busyb, 1);
      end else begin
        chk("trace3_done", doneb, 1);
      end
      if (j <= 8) chk("done_latency", done, j == 8);
      if (j == 8) begin
        chk("pass_tt", tt_out, 8'b0001_1000);
        chk("pass_mismatch", mismatch, 0);
        chk("pass_pass", pass, 1);
        chk("pass_rv", rv, 1);
      end
      if (j < 16) tick();
    end
    tick();

    // slice 0 mismatch
    exp_tt = 8'b0001_0111;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("mis_done", done, 1);
    chk("mis_mismatch", mismatch, 2'b01);
    chk("mis_pass", pass, 0);
    chk("mis_rv", rv, 1);
    tick();

    // abort on second capture: only the v=0 bits change
    bank_tt = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rv", rv, 0);
    chk("abort_tt", tt_out, 8'b0001_1001);
    chk("abort_mismatch", mismatch, 2'b01);
    chk("abort_pass", pass, 0);
    tick();
    chk("abort_no_done", done, 0);
    bank_tt = 8'b0001_1000;
    exp_tt  = 8'b0001_1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("after_abort_done", done, 1);
    chk("after_abort_pass", pass, 1);
    chk("after_abort_tt", tt_out, 8'b0001_1000);
    tick();

    // async reset mid-SETTLE
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {x1, x0, busy, done, pass, rv, tt_out, mismatch}, 0);
    chk("midreset_dut3", {busyb, doneb, rvb, tt_outb}, 0);
    #2 rst_n = 1'b1;
    repeat (5) tick();
    repeat (20) tick();

    // random traffic
    repeat (4000) begin
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (m_phase == 0 && $urandom_range(0, 2) == 0) begin
        bank_tt = 8'($urandom);
        r = $urandom_range(0, 2);
        if (r == 0) exp_tt = bank_tt;
        else if (r == 1) exp_tt = bank_tt ^ (8'd1 << $urandom_range(0, 7));
        else exp_tt = 8'($urandom);
      end
      start = ($urandom_range(0, 4) == 0);
      abort = ($urandom_range(0, 19) == 0);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
